// File: rtl/dmem_responder.sv
// Data-memory responder behind the CPU load/store unit.
// Accepts right-aligned LSU requests, byte-lanes them into a word RAM after
// WAIT_CYCLES wait states, and returns right-aligned load data.
// Misaligned, illegal-strobe and out-of-range accesses answer with an error
// and leave memory untouched.
//
// Handshake: a request transfers on a rising edge where i_req_valid and
// o_req_ready are both 1; a response transfers on a rising edge where
// o_rsp_valid and i_rsp_ready are both 1. Only one request is outstanding, so
// o_req_ready is 0 from the accept edge until the edge after the response
// transfer. The requester holds its request stable until it is accepted.
module dmem_responder #(
    parameter int               XLEN        = 32,
    parameter int               BYTE_WIDTH  = 8,
    parameter int               DEPTH_WORDS = 1024,
    parameter logic [XLEN-1:0]  BASE_ADDR   = 32'h0000_0000,
    parameter int               WAIT_CYCLES = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_req_valid,
    output logic                       o_req_ready,
    input  logic                       i_req_we,
    input  logic [XLEN-1:0]            i_addr,
    input  logic [XLEN-1:0]            i_wdata,
    input  logic [XLEN/BYTE_WIDTH-1:0] i_wstrb,
    output logic                       o_rsp_valid,
    input  logic                       i_rsp_ready,
    output logic [XLEN-1:0]            o_rdata,
    output logic                       o_rsp_err,
    output logic [1:0]                 o_dbg_state
);

    localparam int NB    = XLEN / BYTE_WIDTH;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [XLEN:0] SPAN     = (XLEN+1)'(DEPTH_WORDS * NB);
    localparam logic [3:0]    CNT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [XLEN-1:0]     rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                we_q;
    logic [XLEN-1:0]     addr_q, wdata_q;
    logic [NB-1:0]       wstrb_q;
    logic                latch;
    logic                mem_we;

    logic [XLEN-1:0]     mem [DEPTH_WORDS];

    logic                acc_we;
    logic [XLEN-1:0]     acc_addr, acc_wdata;
    logic [NB-1:0]       acc_wstrb;
    logic [OFF_W-1:0]    off;
    logic                below_base;
    logic [XLEN-1:0]     rel;
    logic                strb_ok, range_ok, fault;
    logic [IDX_W-1:0]    idx;
    logic [NB-1:0]       lane_strb;
    logic [XLEN-1:0]     lane_data;
    logic [XLEN-1:0]     word, shifted, load_data, result;

    // In IDLE the access uses the live request (WAIT_CYCLES = 0 case);
    // later it uses the copy latched at the accept edge.
    always_comb begin
        acc_we    = (state_q == ST_IDLE) ? i_req_we : we_q;
        acc_addr  = (state_q == ST_IDLE) ? i_addr   : addr_q;
        acc_wdata = (state_q == ST_IDLE) ? i_wdata  : wdata_q;
        acc_wstrb = (state_q == ST_IDLE) ? i_wstrb  : wstrb_q;
    end

    // Fault decode, byte-lane steering and right-aligned load extraction.
    always_comb begin
        off                 = acc_addr[OFF_W-1:0];
        {below_base, rel}   = {1'b0, acc_addr} - {1'b0, BASE_ADDR};
        strb_ok  = (acc_wstrb == NB'(1))
                || ((acc_wstrb == NB'(3)) && !off[0])
                || ((acc_wstrb == '1) && (off == '0));
        range_ok = !below_base && ({1'b0, rel} < SPAN);
        fault    = !(strb_ok && range_ok);
        idx       = rel[IDX_W+OFF_W-1:OFF_W];
        lane_strb = acc_wstrb << off;
        lane_data = acc_wdata << (BYTE_WIDTH * off);
        word      = mem[idx];
        shifted   = word >> (BYTE_WIDTH * off);
        load_data = '0;
        for (int b = 0; b < NB; b++) begin
            if (acc_wstrb[b]) begin
                load_data[b*BYTE_WIDTH +: BYTE_WIDTH] = shifted[b*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        result = acc_we ? '0 : load_data;
    end

    // Next-state, wait counter and response capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        latch   = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_req_valid) begin
                    latch = 1'b1;
                    if (fault) begin
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else if (WAIT_CYCLES == 0) begin
                        state_d = ST_RESP;
                        err_d   = 1'b0;
                        rdata_d = result;
                        mem_we  = acc_we;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    err_d   = fault;
                    rdata_d = fault ? '0 : result;
                    mem_we  = acc_we && !fault;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register plus request latch; reset abandons any request in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (latch) begin
                we_q    <= i_req_we;
                addr_q  <= i_addr;
                wdata_q <= i_wdata;
                wstrb_q <= i_wstrb;
            end
        end
    end

    // Byte-enabled RAM write; contents are deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (mem_we && !i_rst) begin
            for (int b = 0; b < NB; b++) begin
                if (lane_strb[b]) begin
                    mem[idx][b*BYTE_WIDTH +: BYTE_WIDTH] <= lane_data[b*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    assign o_req_ready = (state_q == ST_IDLE);
    assign o_rsp_valid = (state_q == ST_RESP);
    assign o_rdata     = rdata_q;
    assign o_rsp_err   = err_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: stores/loads of each width, faults,
// response backpressure and reset in the middle of a transaction.
module tb_dmem_responder;

    localparam int WAIT_CYCLES = 1;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic [3:0]  i_wstrb;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rdata;
    logic        o_rsp_err;
    logic [1:0]  o_dbg_state;

    int checks   = 0;
    int failures = 0;

    // Clock and reset-free free-running clock, 10 time units per period.
    always #5 i_clk = ~i_clk;

    dmem_responder #(
        .XLEN        (32),
        .BYTE_WIDTH  (8),
        .DEPTH_WORDS (1024),
        .BASE_ADDR   (32'h0000_0000),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_we    (i_req_we),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .i_wstrb     (i_wstrb),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rdata     (o_rdata),
        .o_rsp_err   (o_rsp_err),
        .o_dbg_state (o_dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 unit after the edge.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // One complete request/response with immediate response acceptance.
    task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb,
                       input logic exp_err, input logic [31:0] exp_rdata);
        int lat;
        i_req_valid = 1'b1;
        i_req_we    = we;
        i_addr      = addr;
        i_wdata     = wdata;
        i_wstrb     = strb;
        chk($sformatf("%s_req_ready", tag), 32'(o_req_ready), 32'd1);
        step();
        i_req_valid = 1'b0;
        lat = 0;
        while (o_rsp_valid !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        chk($sformatf("%s_latency", tag), 32'(lat), exp_err ? 32'd0 : 32'(WAIT_CYCLES));
        chk($sformatf("%s_err", tag), 32'(o_rsp_err), 32'(exp_err));
        chk($sformatf("%s_rdata", tag), o_rdata, exp_rdata);
        i_rsp_ready = 1'b1;
        step();
        i_rsp_ready = 1'b0;
        chk($sformatf("%s_valid_clr", tag), 32'(o_rsp_valid), 32'd0);
        chk($sformatf("%s_idle", tag), 32'(o_req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        i_rst       = 1'b1;
        i_req_valid = 1'b0;
        i_req_we    = 1'b0;
        i_addr      = '0;
        i_wdata     = '0;
        i_wstrb     = '0;
        i_rsp_ready = 1'b0;
        step();
        step();
        chk("rst_valid", 32'(o_rsp_valid), 32'd0);
        chk("rst_ready", 32'(o_req_ready), 32'd1);
        chk("rst_rdata", o_rdata, 32'd0);
        chk("rst_err",   32'(o_rsp_err), 32'd0);
        chk("rst_state", 32'(o_dbg_state), 32'd0);
        i_rst = 1'b0;
        step();

        // Word, byte and halfword stores and loads.
        txn("sw10",   1'b1, 32'h10, 32'h1234_5678, 4'b1111, 1'b0, 32'h0);
        txn("lw10a",  1'b0, 32'h10, 32'h0,         4'b1111, 1'b0, 32'h1234_5678);
        txn("sb13",   1'b1, 32'h13, 32'h0000_00AA, 4'b0001, 1'b0, 32'h0);
        txn("lw10b",  1'b0, 32'h10, 32'h0,         4'b1111, 1'b0, 32'hAA34_5678);
        txn("lbu13",  1'b0, 32'h13, 32'h0,         4'b0001, 1'b0, 32'h0000_00AA);
        txn("lb11",   1'b0, 32'h11, 32'h0,         4'b0001, 1'b0, 32'h0000_0056);
        txn("lh12",   1'b0, 32'h12, 32'h0,         4'b0011, 1'b0, 32'h0000_AA34);
        txn("sw14",   1'b1, 32'h14, 32'h2468_1357, 4'b1111, 1'b0, 32'h0);
        txn("sh16",   1'b1, 32'h16, 32'h0000_BEEF, 4'b0011, 1'b0, 32'h0);
        txn("lh16",   1'b0, 32'h16, 32'h0,         4'b0011, 1'b0, 32'h0000_BEEF);
        txn("lw14a",  1'b0, 32'h14, 32'h0,         4'b1111, 1'b0, 32'hBEEF_1357);
        txn("sh14",   1'b1, 32'h14, 32'hFFFF_5A5A, 4'b0011, 1'b0, 32'h0);
        txn("lw14b",  1'b0, 32'h14, 32'h0,         4'b1111, 1'b0, 32'hBEEF_5A5A);
        txn("sw0",    1'b1, 32'h0,   32'h0102_0304, 4'b1111, 1'b0, 32'h0);
        txn("swtop",  1'b1, 32'hFFC, 32'h0BAD_F00D, 4'b1111, 1'b0, 32'h0);
        txn("lwtop",  1'b0, 32'hFFC, 32'h0,         4'b1111, 1'b0, 32'h0BAD_F00D);

        // Faults: error response with zero data, memory untouched.
        txn("f_sw11",  1'b1, 32'h11,   32'hFFFF_FFFF, 4'b1111, 1'b1, 32'h0);
        txn("lw10c",   1'b0, 32'h10,   32'h0,         4'b1111, 1'b0, 32'hAA34_5678);
        txn("f_sh15",  1'b1, 32'h15,   32'h0000_FFFF, 4'b0011, 1'b1, 32'h0);
        txn("lw14c",   1'b0, 32'h14,   32'h0,         4'b1111, 1'b0, 32'hBEEF_5A5A);
        txn("f_s0101", 1'b1, 32'h10,   32'hFFFF_FFFF, 4'b0101, 1'b1, 32'h0);
        txn("lw10d",   1'b0, 32'h10,   32'h0,         4'b1111, 1'b0, 32'hAA34_5678);
        txn("f_l0000", 1'b0, 32'h10,   32'h0,         4'b0000, 1'b1, 32'h0);
        txn("lw10e",   1'b0, 32'h10,   32'h0,         4'b1111, 1'b0, 32'hAA34_5678);
        txn("f_lw12",  1'b0, 32'h12,   32'h0,         4'b1111, 1'b1, 32'h0);
        txn("f_oor",   1'b1, 32'h1000, 32'hFFFF_FFFF, 4'b1111, 1'b1, 32'h0);
        txn("lw0",     1'b0, 32'h0,    32'h0,         4'b1111, 1'b0, 32'h0102_0304);
        txn("lhtop",   1'b0, 32'hFFE,  32'h0,         4'b0011, 1'b0, 32'h0000_0BAD);

        // Backpressure: response held, competing request refused until after handshake.
        txn("sw30", 1'b1, 32'h30, 32'h1111_1111, 4'b1111, 1'b0, 32'h0);
        i_req_valid = 1'b1;
        i_req_we    = 1'b0;
        i_addr      = 32'h10;
        i_wstrb     = 4'b1111;
        step();
        i_req_we    = 1'b1;
        i_addr      = 32'h30;
        i_wdata     = 32'h9999_9999;
        step();
        chk("bp_first_valid", 32'(o_rsp_valid), 32'd1);
        for (int c = 0; c < 5; c++) begin
            step();
            chk($sformatf("bp_valid_%0d", c), 32'(o_rsp_valid), 32'd1);
            chk($sformatf("bp_rdata_%0d", c), o_rdata, 32'hAA34_5678);
            chk($sformatf("bp_err_%0d", c),   32'(o_rsp_err), 32'd0);
            chk($sformatf("bp_ready_%0d", c), 32'(o_req_ready), 32'd0);
        end
        i_rsp_ready = 1'b1;
        step();
        i_rsp_ready = 1'b0;
        chk("bp_hs_valid", 32'(o_rsp_valid), 32'd0);
        chk("bp_hs_state", 32'(o_dbg_state), 32'd0);
        chk("bp_hs_ready", 32'(o_req_ready), 32'd1);
        i_req_valid = 1'b0;
        step();
        txn("lw30", 1'b0, 32'h30, 32'h0, 4'b1111, 1'b0, 32'h1111_1111);

        // Reset while a store waits: the store is abandoned.
        txn("sw20",  1'b1, 32'h20, 32'hCAFE_F00D, 4'b1111, 1'b0, 32'h0);
        txn("lw10f", 1'b0, 32'h10, 32'h0,         4'b1111, 1'b0, 32'hAA34_5678);
        i_req_valid = 1'b1;
        i_req_we    = 1'b1;
        i_addr      = 32'h20;
        i_wdata     = 32'hDEAD_BEEF;
        i_wstrb     = 4'b1111;
        step();
        i_req_valid = 1'b0;
        chk("rw_state_wait", 32'(o_dbg_state), 32'd1);
        i_rst = 1'b1;
        step();
        chk("rw_valid", 32'(o_rsp_valid), 32'd0);
        chk("rw_ready", 32'(o_req_ready), 32'd1);
        chk("rw_rdata", o_rdata, 32'd0);
        chk("rw_err",   32'(o_rsp_err), 32'd0);
        chk("rw_state", 32'(o_dbg_state), 32'd0);
        i_rst = 1'b0;
        step();
        txn("lw20", 1'b0, 32'h20, 32'h0, 4'b1111, 1'b0, 32'hCAFE_F00D);

        // Reset while a response is pending: the response is dropped.
        i_req_valid = 1'b1;
        i_req_we    = 1'b0;
        i_addr      = 32'h14;
        i_wstrb     = 4'b1111;
        step();
        i_req_valid = 1'b0;
        step();
        chk("rr_pending", 32'(o_rsp_valid), 32'd1);
        i_rst = 1'b1;
        step();
        chk("rr_valid", 32'(o_rsp_valid), 32'd0);
        chk("rr_rdata", o_rdata, 32'd0);
        i_rst = 1'b0;
        step();
        txn("lw14d", 1'b0, 32'h14, 32'h0, 4'b1111, 1'b0, 32'hBEEF_5A5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder that sits on the far side of the CPU load/store unit. It accepts LSU-formatted requests: store data right-aligned in the low bytes, a byte strobe of 0001/0011/1111, and a full byte address. It byte-lanes the data into a word-organised RAM with configurable wait states. It returns load data right-aligned so the LSU can sign- or zero-extend it. Misaligned, illegal-strobe and out-of-range accesses complete with an error response and never touch memory.

Parameters:
XLEN, 32, data/address width (matches cotm32_pkg)
BYTE_WIDTH, 8, bits per byte lane
DEPTH_WORDS, 1024, RAM depth in XLEN-bit words
BASE_ADDR, 32'h0000_0000, byte address of word 0
WAIT_CYCLES, 1, extra cycles between accept and access (0..15)

Ports:
i_clk  in  1  clock, all state changes on rising edge
i_rst  in  1  synchronous, active-high reset
i_req_valid  in  1  request present
o_req_ready  out  1  responder can accept a request this cycle
i_req_we  in  1  1 = store, 0 = load
i_addr  in  XLEN  byte address
i_wdata  in  XLEN  store data, right-aligned (LSU o_wdata)
i_wstrb  in  XLEN/BYTE_WIDTH  access width, right-aligned (LSU o_wstrb); used for loads too
o_rsp_valid  out  1  response present
i_rsp_ready  in  1  consumer takes response
o_rdata  out  XLEN  load data, right-aligned, upper bytes zero
o_rsp_err  out  1  access faulted; qualified by o_rsp_valid

Behaviour:
- One clock (i_clk); reset is synchronous and active-high (i_rst).
- Reset values:
  - state = IDLE, wait counter = 0
  - o_req_ready = 1 (combinational from IDLE)
  - o_rsp_valid = 0, o_rdata = 0, o_rsp_err = 0
  - RAM contents not reset.
- FSM states are IDLE, WAIT and RESP. At most one request is outstanding.
  - IDLE: o_req_ready = 1. On i_req_valid, latch we/addr/wdata/wstrb at the edge (accept).
    - If the request faults: go to RESP with err = 1 and rdata = 0.
    - Else if WAIT_CYCLES = 0: perform the access at the accept edge and go to RESP.
    - Else: load counter = WAIT_CYCLES - 1 and go to WAIT.
  - WAIT: o_req_ready = 0. Decrement the counter. When the counter = 0, perform the access at that edge and go to RESP.
  - RESP: o_rsp_valid = 1; o_rdata and o_rsp_err are stable. When i_rsp_ready = 1, go to IDLE and clear o_rsp_valid. A new request cannot be accepted in that same cycle.
- Latency: request accepted at edge N gives o_rsp_valid high from cycle N+1+WAIT_CYCLES.
- Fault checks, with off = addr[1:0]:
  - Strobe not in {0001, 0011, 1111} → err.
  - 0011 with off[0] = 1 → err.
  - 1111 with off ≠ 0 → err.
  - addr < BASE_ADDR or addr - BASE_ADDR ≥ DEPTH_WORDS*4 → err.
- Word index = (addr - BASE_ADDR) >> 2.
- Store:
  - Lane strobe = wstrb << off; lane data = wdata << (8*off).
  - Write only bytes whose lane strobe bit is set; other bytes are preserved.
  - o_rdata = 0 on a store response.
- Load: o_rdata = (word >> (8*off)) masked by wstrb expanded to bytes; unselected upper bytes are 0.
- Reset mid-operation:
  - Reset in WAIT abandons the request; a pending store is not written.
  - Reset in RESP drops the response.
- Request inputs are ignored outside IDLE. The requester must hold them stable until accepted.

Test Plan:
- WAIT_CYCLES=1. SW addr 0x10, wdata 0x12345678, wstrb 1111 → accept edge N, o_rsp_valid at N+2, err 0. Then LW addr 0x10 → o_rdata 0x12345678.
- After the word holds 0x12345678: SB addr 0x13, wdata 0x000000AA, wstrb 0001 → word becomes 0xAA345678. LBU-style load addr 0x13, wstrb 0001 → o_rdata 0x000000AA.
- SH addr 0x16, wdata 0x0000BEEF, wstrb 0011 → bytes 0x16/0x17 updated. Load addr 0x16, wstrb 0011 → o_rdata 0x0000BEEF; load addr 0x14, wstrb 1111 → 0xBEEFxxxx with low half unchanged.
- Faults each give o_rsp_valid with err 1 and memory unchanged:
  - SW addr 0x11, wstrb 1111
  - SH addr 0x15, wstrb 0011
  - wstrb 0101
  - addr BASE_ADDR + 4*DEPTH_WORDS
- Backpressure: hold i_rsp_ready = 0 for 5 cycles → o_rsp_valid, o_rdata and err stay stable and o_req_ready stays 0. A new i_req_valid is not accepted until the cycle after the response handshake.
- Assert i_rst during WAIT of SW 0xDEADBEEF to addr 0x20 → outputs return to reset values next cycle. A later load of addr 0x20 returns the prior contents.
